// File: rtl/mem_bank_pkg.sv
// mem_bank_nr shared types: FSM states, digit classes, classifier helper.
// The illegal-code flag is built only with MEM_BANK_ERR_CHK_EN defined.
package mem_bank_pkg;

  typedef enum logic [1:0] {
    WAIT_DATA,
    CAPTURE,
    WAIT_NULL
  } state_t;

  typedef enum logic [1:0] {
    SPACER,
    VALID,
    ILLEGAL
  } dclass_t;

  localparam int SPACER_WORD = 0;

  // Narrower digits are zero-extended by the caller.
  function automatic dclass_t onehot_class(
    input logic [31:0] digit
  );
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(digit[i]);
    end
    if (n == 0) return SPACER;
    if (n == 1) return VALID;
    return ILLEGAL;
  endfunction

endpackage

// File: rtl/rail_digit_chk.sv
// mem_bank_nr per-digit classifier for a 1-of-RAIL_NUM code.
// Flags a digit as a valid code word or as an illegal multi-hot.
import mem_bank_pkg::*;

module rail_digit_chk #(
  parameter int RAIL_NUM = 2
) (
  input  logic [RAIL_NUM-1:0] i_digit,
  output logic                o_valid,
  output logic                o_illegal
);

  dclass_t w_cls;

  always_comb begin
    w_cls     = onehot_class(32'(i_digit));
    o_valid   = (w_cls == VALID);
    o_illegal = (w_cls == ILLEGAL);
  end

endmodule

// File: rtl/mem_bank_nr.sv
// mem_bank_nr: clocked storage bank for 1-of-N words on a 4-phase RZ link.
// Define MEM_BANK_ERR_CHK_EN to build the sticky illegal-code flag err.
import mem_bank_pkg::*;

module mem_bank_nr #(
  parameter  int RAIL_NUM = 2,
  parameter  int DIGITS   = 8,
  parameter  int DEPTH    = 4,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int WW       = DIGITS * RAIL_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lat_i,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WW-1:0]     in,
  output logic              in_ack,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WW-1:0]     out,
  output logic              out_vld,
  output logic              err
);

  logic [WW-1:0] r_s1, r_s2, r_s3;
  logic [WW-1:0] r_mem [DEPTH];
  logic [WW-1:0] r_out;
  logic          r_vld;
  logic          r_ack;
  state_t        r_state, w_nxt;
  logic          w_cap;

  logic [DIGITS-1:0] w_valid;
  logic [DIGITS-1:0] w_illegal;
  logic w_complete, w_null, w_any_ill;
  logic w_stable, w_go;
  logic w_wr_ok, w_rd_ok;

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    rail_digit_chk #(.RAIL_NUM(RAIL_NUM)) u_chk (
      .i_digit  (r_s2[d*RAIL_NUM +: RAIL_NUM]),
      .o_valid  (w_valid[d]),
      .o_illegal(w_illegal[d])
    );
  end

  assign w_complete = &w_valid;
  assign w_any_ill  = |w_illegal;
  assign w_null     = (r_s2 == WW'(SPACER_WORD));
  assign w_stable   = (r_s2 == r_s3);
  assign w_go       = w_complete & w_stable
                    & ~w_any_ill & ~lat_i;
  assign w_wr_ok    = (32'(wr_addr) < DEPTH);
  assign w_rd_ok    = (32'(rd_addr) < DEPTH);

  always_comb begin
    w_nxt = r_state;
    w_cap = 1'b0;
    unique case (r_state)
      WAIT_DATA: begin
        if (w_go) begin
          w_nxt = CAPTURE;
          w_cap = 1'b1;
        end
      end
      CAPTURE:   w_nxt = WAIT_NULL;
      WAIT_NULL: begin
        if (w_null) w_nxt = WAIT_DATA;
      end
      default:   w_nxt = WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_s3    <= '0;
      r_state <= WAIT_DATA;
      r_ack   <= 1'b0;
    end else begin
      r_s1    <= in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_state <= w_nxt;
      if (w_cap) begin
        r_ack <= 1'b1;
      end else if (r_state == WAIT_NULL && w_null) begin
        r_ack <= 1'b0;
      end
    end
  end

  // Write and read share the edge; nonblocking gives read-before-write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= WW'(SPACER_WORD);
      end
      r_out <= WW'(SPACER_WORD);
      r_vld <= 1'b0;
    end else begin
      if (w_cap && w_wr_ok) begin
        r_mem[wr_addr] <= r_s3;
      end
      r_vld <= rd_en;
      if (rd_en) begin
        r_out <= w_rd_ok ? r_mem[rd_addr]
                         : WW'(SPACER_WORD);
      end
    end
  end

`ifdef MEM_BANK_ERR_CHK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (r_state == WAIT_DATA && w_any_ill) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign in_ack  = r_ack;
  assign out     = r_out;
  assign out_vld = r_vld;

endmodule

// File: doc/mem_bank_nr.md
Name: mem_bank_nr

Overview:
- Clocked, parametrised multi-word storage bank for 1-of-N (RAIL_NUM-rail) encoded words arriving on a four-phase return-to-zero link.
- Successor to the single dual-rail latch cell: DEPTH words × DIGITS digits, with completion detection and a req/ack write handshake instead of a bare transparent latch.
- Synchronous addressed read port.
- Bridges async-encoded producer links into the clocked domain.

Parameters:
- RAIL_NUM, 2, rails per digit; 1-of-RAIL_NUM code, spacer = all rails 0.
- DIGITS, 8, digits per word.
- DEPTH, 4, words stored; must be ≥2.
- ADDR_W, $clog2(DEPTH), localparam, address width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- lat_i  in  1  hold: when 1, new captures are blocked; the bank is frozen against writes.
- wr_addr  in  ADDR_W  write address; sampled at capture.
- in  in  DIGITS*RAIL_NUM  encoded write word; digit d occupies bits [d*RAIL_NUM +: RAIL_NUM].
- in_ack  out  1  four-phase acknowledge to producer.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- out  out  DIGITS*RAIL_NUM  encoded read word.
- out_vld  out  1  one-cycle pulse; out updated this cycle.
- err  out  1  sticky illegal-code flag (feature-dependent).

Behaviour:
- Reset (rst=0, asynchronous):
  - in_ack=0, out=0 (spacer), out_vld=0, err=0.
  - All memory words are spacer; sync stages cleared; FSM goes to WAIT_DATA.
  - Reset mid-handshake drops in_ack immediately; no partial write occurs.
- Input sync: three flop stages s1→s2→s3 on every bit of in.
- Digit classification (per digit, on s2):
  - SPACER: all rails 0.
  - VALID: exactly one rail 1.
  - ILLEGAL: more than one rail 1.
  - Word COMPLETE: all digits VALID. Word NULL: all digits SPACER.
- FSM:
  - WAIT_DATA → CAPTURE when s2 is COMPLETE, s2==s3 (stable for one extra cycle), and lat_i=0.
    - Mixed spacer/valid words keep waiting.
    - While lat_i=1, the FSM stays in WAIT_DATA even if the word is complete.
  - CAPTURE (one cycle): mem[wr_addr] <= s3; in_ack <= 1; → WAIT_NULL.
  - WAIT_NULL → WAIT_DATA when s2 is NULL; in_ack <= 0 on that edge.
    - lat_i does not block release.
- Latency:
  - in complete and stable before edge 1 → in_ack high after edge 4.
  - in returns to spacer before edge 1 → in_ack low after edge 3.
- Write address: wr_addr must be stable from in going complete until in_ack rises; the value used is the one sampled at the CAPTURE edge.
- Read:
  - rd_en=1 at edge t → out=mem[rd_addr] and out_vld=1 after edge t; out_vld=0 after edge t+1.
  - out holds its value between reads.
  - A read of a never-written word returns spacer.
- Read/write same edge, same address: read returns the old contents (read-before-write).
- Address ≥ DEPTH: writes are dropped (in_ack handshake still completes); reads return spacer.

Optional Feature:
- Macro: MEM_BANK_ERR_CHK_EN.
- Defined:
  - Any ILLEGAL digit in s2 while in WAIT_DATA sets err=1 (sticky until reset).
  - The FSM stays in WAIT_DATA, and the ILLEGAL word is never captured.
  - The producer must return to spacer. A following legal word is accepted normally; err stays 1.
- Undefined:
  - err tied to 0.
  - ILLEGAL digits are simply not VALID, so the word never completes and the FSM waits.

Decomposition:
- Package mem_bank_pkg:
  - State enum (WAIT_DATA, CAPTURE, WAIT_NULL).
  - Digit class enum (SPACER, VALID, ILLEGAL).
  - Function onehot_class(digit).
  - Localparam SPACER_WORD = 0.
- One sub-module, rail_digit_chk: per-digit classifier, instantiated DIGITS times; outputs valid and illegal.

Test Plan:
All cases use RAIL_NUM=2, DIGITS=4, DEPTH=4; rail0 encodes logic 0, rail1 encodes logic 1.
- Reset, then rd_en at addresses 0..3 → out=8'h00 with a single out_vld pulse per read; in_ack=0, err=0.
- Write 4'b1010 (in=8'b10011001) at wr_addr=2, then in=0 → in_ack high exactly 4 edges after apply and low 3 edges after spacer; read addr 2 → out=8'b10011001.
- Assert lat_i=1, apply a complete word → in_ack stays 0 indefinitely. Drop lat_i → in_ack rises 1 edge later, and the word is stored.
- Apply half-complete in=8'b00001001 for 10 cycles → no ack, memory unchanged. Completing to 8'b01011001 → ack, and 8'b01011001 is stored.
- Same edge: rd_en at addr 1 plus a write capture to addr 1 (old 8'h55, new 8'hAA) → out=8'h55 that cycle; next read gives 8'hAA.
- With MEM_BANK_ERR_CHK_EN defined: in=8'b11010101 → err=1, no ack. Then spacer, then 8'b01010101 → write accepted, err remains 1 until rst=0. Also pulse rst low while in_ack=1 → in_ack=0 immediately and all words read back as spacer.
